// File: rtl/postage_sched_pkg.sv
// rtl/postage_sched_pkg.sv - shared types and width helpers for the postage stamp scheduler
package postage_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFFER  = 2'd1,
        ST_STREAM = 2'd2
    } sched_state_t;

    localparam int DEF_N_CHAN    = 8;
    localparam int DEF_STAMP_LEN = 128;
    localparam int DEF_TIMEOUT   = 1024;
    localparam int DEF_CNT_W     = 16;

    // Counter widths never drop below one bit, even for degenerate parameters.
    function automatic int clog2_min1(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction

    localparam int CHAN_W  = clog2_min1(DEF_N_CHAN);
    localparam int BEAT_W  = clog2_min1(DEF_STAMP_LEN);
    localparam int STALL_W = clog2_min1(DEF_TIMEOUT);

endpackage

// File: rtl/postage_rr_arbiter.sv
// rtl/postage_rr_arbiter.sv - combinational rotating-priority pick of the first request at or after ptr
module postage_rr_arbiter
    import postage_sched_pkg::*;
#(
    parameter int N_CHAN = DEF_N_CHAN,
    parameter int C_W    = clog2_min1(DEF_N_CHAN)
) (
    input  logic [N_CHAN-1:0] i_req,
    input  logic [C_W-1:0]    i_ptr,
    output logic [C_W-1:0]    o_gnt_idx,
    output logic              o_gnt_any
);

    int w_k;

    // Walk from the farthest candidate back to ptr so the nearest set bit is assigned last.
    always_comb begin
        o_gnt_idx = '0;
        o_gnt_any = 1'b0;
        w_k       = 0;
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            w_k = (int'(i_ptr) + i) % N_CHAN;
            if (i_req[w_k[C_W-1:0]]) begin
                o_gnt_idx = w_k[C_W-1:0];
                o_gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/postage_stamp_scheduler.sv
// rtl/postage_stamp_scheduler.sv - round-robin grant of the postage-stamp capture engine with stall watchdog
module postage_stamp_scheduler
    import postage_sched_pkg::*;
#(
    parameter int N_CHAN    = DEF_N_CHAN,
    parameter int STAMP_LEN = DEF_STAMP_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_CHAN-1:0]         i_trig,
    output logic                      o_sel_valid,
    output logic [$clog2(N_CHAN)-1:0] o_sel_chan,
    input  logic                      i_sel_ready,
    input  logic                      i_beat_valid,
    input  logic                      i_beat_ready,
    output logic                      o_last,
    output logic                      o_busy,
    output logic [N_CHAN-1:0]         o_pending,
    output logic [CNT_W-1:0]          o_drop_count,
    output logic                      o_timeout_err
);

    localparam int C_W   = $clog2(N_CHAN);
    localparam int B_W   = clog2_min1(STAMP_LEN);
    localparam int S_W   = clog2_min1(TIMEOUT);
    localparam int DN_W  = $clog2(N_CHAN + 1);
    localparam int SUM_W = ((CNT_W > DN_W) ? CNT_W : DN_W) + 1;

    localparam logic [B_W-1:0]   LAST_BEAT = B_W'(STAMP_LEN - 1);
    localparam logic [S_W-1:0]   STALL_MAX = S_W'(TIMEOUT - 1);
    localparam logic [C_W-1:0]   CHAN_MAX  = C_W'(N_CHAN - 1);
    localparam logic [SUM_W-1:0] DROP_MAX  = SUM_W'({CNT_W{1'b1}});

    sched_state_t r_state;
    sched_state_t w_state_nxt;

    logic              r_sel_valid;
    logic [C_W-1:0]    r_sel_chan;
    logic [C_W-1:0]    r_rr_ptr;
    logic [N_CHAN-1:0] r_pending;
    logic [CNT_W-1:0]  r_drop_count;
    logic              r_timeout_err;
    logic [B_W-1:0]    r_beat_cnt;
    logic [S_W-1:0]    r_stall_cnt;

    logic [C_W-1:0]    w_gnt_idx;
    logic              w_gnt_any;
    logic              w_start;
    logic              w_beat_acc;
    logic              w_final_beat;
    logic              w_timeout;
    logic [N_CHAN-1:0] w_clear_mask;
    logic [N_CHAN-1:0] w_drop_bits;
    logic [DN_W-1:0]   w_drop_n;
    logic [SUM_W-1:0]  w_drop_sum;
    logic [CNT_W-1:0]  w_drop_nxt;
    logic [C_W-1:0]    w_ptr_nxt;

    postage_rr_arbiter #(
        .N_CHAN (N_CHAN),
        .C_W    (C_W)
    ) u_arb (
        .i_req     (r_pending),
        .i_ptr     (r_rr_ptr),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_any (w_gnt_any)
    );

    assign w_start      = (r_state == ST_OFFER) && i_sel_ready;
    assign w_beat_acc   = (r_state == ST_STREAM) && i_beat_valid && i_beat_ready;
    assign w_final_beat = w_beat_acc && (r_beat_cnt == LAST_BEAT);
    assign w_ptr_nxt    = (r_sel_chan == CHAN_MAX) ? '0 : r_sel_chan + 1'b1;
    assign w_clear_mask = w_start ? (N_CHAN'(1) << r_sel_chan) : '0;
    assign w_drop_bits  = i_trig & r_pending & ~w_clear_mask;

    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < N_CHAN; i++) begin
            w_drop_n = w_drop_n + DN_W'(w_drop_bits[i]);
        end
        w_drop_sum = SUM_W'(r_drop_count) + SUM_W'(w_drop_n);
        w_drop_nxt = (w_drop_sum > DROP_MAX) ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_any) begin
                    w_state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (i_sel_ready) begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (w_final_beat) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_beat_acc && (r_stall_cnt == STALL_MAX)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sel_valid   <= 1'b0;
            r_sel_chan    <= '0;
            r_rr_ptr      <= '0;
            r_pending     <= '0;
            r_drop_count  <= '0;
            r_timeout_err <= 1'b0;
            r_beat_cnt    <= '0;
            r_stall_cnt   <= '0;
        end else begin
            // A trigger landing on the channel being cleared re-arms it as a fresh request.
            r_pending     <= (r_pending & ~w_clear_mask) | i_trig;
            r_drop_count  <= w_drop_nxt;
            r_timeout_err <= w_timeout;

            if ((r_state == ST_IDLE) && w_gnt_any) begin
                r_sel_chan  <= w_gnt_idx;
                r_sel_valid <= 1'b1;
            end
            if (w_start) begin
                r_sel_valid <= 1'b0;
                r_rr_ptr    <= w_ptr_nxt;
            end

            // Counters idle at zero outside STREAM, so entering STREAM starts them cleared.
            if (r_state == ST_STREAM) begin
                if (w_beat_acc) begin
                    r_stall_cnt <= '0;
                    r_beat_cnt  <= w_final_beat ? '0 : r_beat_cnt + 1'b1;
                end else if (w_timeout) begin
                    r_stall_cnt <= '0;
                    r_beat_cnt  <= '0;
                end else begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end else begin
                r_stall_cnt <= '0;
                r_beat_cnt  <= '0;
            end
        end
    end

    assign o_sel_valid   = r_sel_valid;
    assign o_sel_chan    = r_sel_chan;
    assign o_pending     = r_pending;
    assign o_drop_count  = r_drop_count;
    assign o_timeout_err = r_timeout_err;
    assign o_last        = (r_state == ST_STREAM) && (r_beat_cnt == LAST_BEAT);
    assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_postage_stamp_scheduler.sv
// tb/tb_postage_stamp_scheduler.sv - scoreboard bench for the postage stamp scheduler
module tb_postage_stamp_scheduler;

    localparam int N_CHAN    = 8;
    localparam int STAMP_LEN = 128;
    localparam int TIMEOUT   = 16;
    localparam int CNT_W     = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [N_CHAN-1:0] trig;
    logic              sel_valid;
    logic [2:0]        sel_chan;
    logic              sel_ready;
    logic              beat_valid;
    logic              beat_ready;
    logic              last;
    logic              busy;
    logic [N_CHAN-1:0] pending;
    logic [CNT_W-1:0]  drop_count;
    logic              timeout_err;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int beat_idx = 0;
    int exp_grant_q[$];
    int exp_to_q[$];
    logic       prev_hold = 1'b0;
    logic [2:0] prev_chan = '0;

    postage_stamp_scheduler #(
        .N_CHAN    (N_CHAN),
        .STAMP_LEN (STAMP_LEN),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .i_trig        (trig),
        .o_sel_valid   (sel_valid),
        .o_sel_chan    (sel_chan),
        .i_sel_ready   (sel_ready),
        .i_beat_valid  (beat_valid),
        .i_beat_ready  (beat_ready),
        .o_last        (last),
        .o_busy        (busy),
        .o_pending     (pending),
        .o_drop_count  (drop_count),
        .o_timeout_err (timeout_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: grants, stamp framing and timeouts are scored against the queues.
    always @(negedge clock) begin
        if (reset) begin
            beat_idx  = 0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("offer_hold_valid", 32'(sel_valid), 32'd1);
                chk("offer_hold_chan", 32'(sel_chan), 32'(prev_chan));
            end
            prev_hold = sel_valid && !sel_ready;
            prev_chan = sel_chan;
            if (sel_valid && sel_ready) begin
                if (exp_grant_q.size() == 0) chk("unexpected_grant", 32'(sel_chan), 32'hFFFF);
                else chk("grant_chan", 32'(sel_chan), 32'(exp_grant_q.pop_front()));
                beat_idx = 0;
            end
            if (beat_valid && beat_ready) begin
                if (last) begin
                    chk("last_position", 32'(beat_idx), 32'(STAMP_LEN - 1));
                    beat_idx = 0;
                end else begin
                    if (beat_idx == STAMP_LEN - 1) chk("last_missing", 32'd0, 32'd1);
                    beat_idx++;
                end
            end
            if (timeout_err) begin
                if (exp_to_q.size() == 0) chk("unexpected_timeout", 32'd1, 32'd0);
                else chk("timeout_cycle", 32'(cyc), 32'(exp_to_q.pop_front()));
                beat_idx = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic serve();
        int n = 0;
        while (!sel_valid && n < 20) begin
            tick();
            n++;
        end
        chk("offer_wait", 32'(sel_valid), 32'd1);
        sel_ready = 1'b1;
        tick();
        sel_ready = 1'b0;
    endtask

    task automatic stream(input int nbeats, input bit gaps);
        int acc = 0;
        while (acc < nbeats) begin
            if (gaps) begin
                repeat ($urandom_range(0, 5)) begin
                    if ($urandom_range(0, 1) == 1) begin
                        beat_valid = 1'b1; beat_ready = 1'b0;
                    end else begin
                        beat_valid = 1'b0; beat_ready = 1'($urandom_range(0, 1));
                    end
                    tick();
                end
            end
            beat_valid = 1'b1;
            beat_ready = 1'b1;
            tick();
            acc++;
        end
        beat_valid = 1'b0;
        beat_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_sel_valid"}, 32'(sel_valid), 32'd0);
        chk({tag, "_sel_chan"}, 32'(sel_chan), 32'd0);
        chk({tag, "_last"}, 32'(last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_pending"}, 32'(pending), 32'd0);
        chk({tag, "_drop"}, 32'(drop_count), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got no end expected end");
        $fatal(1);
    end

    initial begin
        int c0;
        logic seen;
        reset = 1'b1; trig = '0; sel_ready = 1'b0; beat_valid = 1'b0; beat_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Single trigger with held-off ready, then a full-rate stamp
        trig = 8'h04;
        exp_grant_q.push_back(2);
        tick();
        trig = '0;
        chk("single_pending", 32'(pending), 32'h04);
        chk("single_early_valid", 32'(sel_valid), 32'd0);
        tick();
        chk("single_valid", 32'(sel_valid), 32'd1);
        chk("single_chan", 32'(sel_chan), 32'd2);
        repeat (5) tick();
        chk("single_chan_held", 32'(sel_chan), 32'd2);
        serve();
        chk("single_busy_stream", 32'(busy), 32'd1);
        stream(STAMP_LEN, 1'b0);
        chk("single_idle", 32'(busy), 32'd0);

        // Fairness from rr_ptr = 0, with backpressure on alternate stamps
        do_reset();
        trig = 8'hFF;
        for (int k = 0; k < N_CHAN; k++) exp_grant_q.push_back(k);
        tick();
        trig = '0;
        for (int k = 0; k < N_CHAN; k++) begin
            serve();
            stream(STAMP_LEN, k[0]);
            chk("b2b_idle", 32'(sel_valid), 32'd0);
            if (k < N_CHAN - 1) begin
                tick();
                chk("b2b_offer", 32'(sel_valid), 32'd1);
            end
        end
        trig = 8'h81;
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(7);
        tick();
        trig = '0;
        repeat (2) begin
            serve();
            stream(STAMP_LEN, 1'b0);
        end

        // Drops on a pending channel, clear-and-set, saturation
        exp_grant_q.push_back(3);
        repeat (3) begin
            trig = 8'h08;
            tick();
            trig = '0;
            tick();
        end
        chk("drop_two", 32'(drop_count), 32'd2);
        chk("drop_offer_chan", 32'(sel_chan), 32'd3);
        sel_ready = 1'b1;
        trig = 8'h08;
        tick();
        sel_ready = 1'b0;
        trig = '0;
        exp_grant_q.push_back(3);
        chk("clear_set_drop", 32'(drop_count), 32'd2);
        chk("clear_set_pending", 32'(pending), 32'h08);
        stream(STAMP_LEN, 1'b0);
        serve();
        stream(STAMP_LEN, 1'b1);
        exp_grant_q.push_back(4);
        trig = 8'h10;
        repeat (6) tick();
        trig = '0;
        chk("drop_saturate", 32'(drop_count), 32'd3);
        serve();
        stream(STAMP_LEN, 1'b0);

        // Watchdog: stall after 10 beats
        trig = 8'h22;
        exp_grant_q.push_back(5);
        exp_grant_q.push_back(1);
        tick();
        trig = '0;
        serve();
        stream(10, 1'b0);
        c0 = cyc;
        exp_to_q.push_back(c0 + TIMEOUT);
        beat_valid = 1'b1;
        beat_ready = 1'b0;
        repeat (TIMEOUT) tick();
        chk("to_pulse", 32'(timeout_err), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_pending_kept", 32'(pending), 32'h02);
        tick();
        beat_valid = 1'b0;
        chk("to_pulse_end", 32'(timeout_err), 32'd0);
        chk("to_next_offer", 32'(sel_valid), 32'd1);
        chk("to_next_chan", 32'(sel_chan), 32'd1);
        serve();
        stream(STAMP_LEN, 1'b1);

        // Reset in the middle of a stamp with other requests pending
        trig = 8'h08;
        exp_grant_q.push_back(3);
        tick();
        trig = '0;
        serve();
        stream(50, 1'b0);
        trig = 8'h30;
        tick();
        trig = '0;
        chk("mid_pending", 32'(pending), 32'h30);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (sel_valid || busy) seen = 1'b1;
        end
        chk("no_grant_after_reset", 32'(seen), 32'd0);

        chk("grants_left", 32'(exp_grant_q.size()), 32'd0);
        chk("timeouts_left", 32'(exp_to_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/postage_stamp_scheduler.md
# postage_stamp_scheduler

Round-robin scheduler that shares the single postage-stamp capture engine among `N_CHAN` photon-trigger channels. It latches per-channel trigger requests and grants one channel at a time through a valid/ready start handshake. It then tracks the engine's output stream to the end of the stamp and aborts a stalled stamp after a timeout. It sits between the per-channel trigger comparators and the postage filter datapath/interconnect.

## Interface
- `N_CHAN`, 8: number of requesting channels, ≥2.
- `STAMP_LEN`, 128: beats per stamp, ≥2.
- `TIMEOUT`, 1024: max cycles without an accepted beat while streaming.
- `CNT_W`, 16: drop counter width.
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `trig`  in  N_CHAN  per-channel trigger pulse, one bit per channel.
- `sel_valid`  out  1  grant offered to the capture engine.
- `sel_chan`  out  clog2(N_CHAN)  granted channel index.
- `sel_ready`  in  1  capture engine accepts the grant.
- `beat_valid`  in  1  downstream stamp stream valid (observed).
- `beat_ready`  in  1  downstream stamp stream ready (observed).
- `last`  out  1  current beat is the final beat of the stamp.
- `busy`  out  1  state is not IDLE.
- `pending`  out  N_CHAN  latched requests.
- `drop_count`  out  CNT_W  saturating count of dropped triggers.
- `timeout_err`  out  1  one-cycle pulse when a stamp is aborted.

## Operation
- States:
  - IDLE: if `pending` is non-zero, register the arbiter winner into `sel_chan` and go to OFFER.
  - OFFER: `sel_valid`=1; `sel_chan` is held stable. On `sel_ready`, clear that channel's pending bit, set `rr_ptr` = (chan+1) mod N_CHAN, and go to STREAM.
  - STREAM: `beat_cnt` increments on each accepted beat (`beat_valid & beat_ready`). `last` = STREAM & (`beat_cnt` == STAMP_LEN-1). When the beat with `last`=1 is accepted, go to IDLE.
- Arbitration: the winner is the first set `pending` bit at or after `rr_ptr`, searching cyclically upward.
- Pending set: `pending[i]` is set by `trig[i]`.
- Drops: `trig[i]` while `pending[i]` is already set, and not cleared in the same cycle, counts as a drop: `drop_count`++, saturating at 2^CNT_W-1.
- Simultaneous clear and trig on the same channel: the pending bit ends set and no drop is counted.
- Trigger on the channel being streamed: sets its pending bit normally; it is a new request.
- Multiple trig bits in one cycle are all latched independently.
- Watchdog: `stall_cnt` is active only in STREAM.
  - It resets on entry to STREAM and on every accepted beat, and increments otherwise.
  - At `stall_cnt` == TIMEOUT-1 with no accepted beat: pulse `timeout_err`, clear `beat_cnt`, go to IDLE.
  - `pending` is untouched by a timeout; the aborted channel is not re-queued.
- OFFER has no timeout; the capture engine must eventually assert `sel_ready`.

## Timing
- All outputs are registered, except `last` and `busy`, which are decoded from registered state and counter.
- Reset values:
  - IDLE state.
  - `sel_valid`=0, `sel_chan`=0, `last`=0, `busy`=0.
  - `pending`=0, `drop_count`=0, `timeout_err`=0.
  - `rr_ptr`=0, `beat_cnt`=0, `stall_cnt`=0.
- Reset during OFFER or STREAM abandons the stamp immediately; no `timeout_err` is raised.
- Latency: `trig` at cycle t gives `pending` at t+1 and `sel_valid` at t+2, provided the scheduler is in IDLE.
- Back-to-back stamps: the final beat is accepted at cycle t, giving IDLE at t+1 and `sel_valid` at t+2.
- `sel_valid` never drops without `sel_ready`, and `sel_chan` never changes while `sel_valid`=1.
- `sel_valid` can only be asserted in OFFER.

## Structure
- Package `postage_sched_pkg`:
  - State enum (IDLE, OFFER, STREAM).
  - Width constants: CHAN_W = clog2(N_CHAN), BEAT_W = clog2(STAMP_LEN), STALL_W = clog2(TIMEOUT).
- Sub-module `postage_rr_arbiter`: combinational rotating-priority pick with inputs `req`[N_CHAN] and `ptr`, and outputs `gnt_idx` and `gnt_any`.
- The FSM, counters and pending register stay in the top module.

## Test plan
- Single trig: `trig`=0x04 at t → `sel_valid`=1 with `sel_chan`=2 at t+2. Hold `sel_ready`=0 for 5 cycles → `sel_chan` stays 2. Then stream 128 beats → `last` only on beat 127, then back to IDLE.
- Fairness: `trig`=0xFF once → grants 0,1,…,7 in order. Then `trig`=0x81 with `rr_ptr`=0 → channel 0 is granted before 7.
- Drops: `trig[3]` pulsed 3 times while pending → `drop_count`=2. Clear and trig in the same cycle → no drop. With CNT_W=2 and 5 drops → `drop_count`=3.
- Timeout: TIMEOUT=16; after 10 beats hold `beat_ready`=0 → `timeout_err` is a single pulse 16 cycles after the last accepted beat, then IDLE, and the next pending channel is offered 2 cycles later.
- Backpressure: random `beat_valid`/`beat_ready` gaps shorter than TIMEOUT → exactly STAMP_LEN accepted beats per grant and no `timeout_err`.
- Reset mid-STREAM (beat 50) with `pending`=0x30 → the next cycle shows every output and `pending` at reset values; no grant follows without a new `trig`.
